// File: rtl/button_event_pkg.sv
// Shared event codes and FSM state encoding for button_event.
// The HELD state only exists when BUTTON_EVENT_LONG_PRESS_EN is defined.
package button_event_pkg;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_LONG    = 2'b11
  } evt_code_t;

`ifdef BUTTON_EVENT_LONG_PRESS_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;
`endif

endpackage

// File: rtl/evt_fifo.sv
// In-order event queue, head visible combinationally; a push is readable one edge later.
// Push while full is accepted only alongside a pop; a pop while empty is ignored.
module evt_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into PRESS/RELEASE (and LONG with BUTTON_EVENT_LONG_PRESS_EN)
// events, queued with latency 1; valid/ready drain, full queue drops and sets sticky overflow.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 25_000_000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          debounced,
  output logic [1:0]                    evt_code,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  state_t    state;
  state_t    state_nxt;
  logic      btn_q;
  logic      rise;
  logic      fall;
  logic      push;
  evt_code_t push_code;
  logic      pop;
  logic      full;
  logic      empty;

  assign rise = debounced & ~btn_q;
  assign fall = ~debounced & btn_q;

`ifdef BUTTON_EVENT_LONG_PRESS_EN
  logic [31:0] hold_cnt;
  logic [31:0] hold_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt <= '0;
    else     hold_cnt <= hold_cnt_nxt;
  end
`else
  if (LONG_CYCLES < 2) begin : g_long_cycles_unused
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      btn_q <= 1'b0;
    end else begin
      state <= state_nxt;
      btn_q <= debounced;
    end
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_code = EVT_NONE;
`ifdef BUTTON_EVENT_LONG_PRESS_EN
    hold_cnt_nxt = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (rise) begin
          push      = 1'b1;
          push_code = EVT_PRESS;
          state_nxt = PRESSED;
`ifdef BUTTON_EVENT_LONG_PRESS_EN
          hold_cnt_nxt = '0;
`endif
        end
      end
      PRESSED: begin
        // A release in the LONG cycle wins: the press never became long.
        if (fall) begin
          push      = 1'b1;
          push_code = EVT_RELEASE;
          state_nxt = IDLE;
        end
`ifdef BUTTON_EVENT_LONG_PRESS_EN
        else if (debounced) begin
          if (hold_cnt != '1) hold_cnt_nxt = hold_cnt + 32'd1;
          if (hold_cnt == LONG_CYCLES - 1) begin
            push      = 1'b1;
            push_code = EVT_LONG;
            state_nxt = HELD;
          end
        end
`endif
      end
`ifdef BUTTON_EVENT_LONG_PRESS_EN
      HELD: begin
        if (fall) begin
          push      = 1'b1;
          push_code = EVT_RELEASE;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign evt_valid = ~empty;
  assign pop       = evt_valid & evt_ready;

  evt_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_code),
    .pop   (pop),
    .dout  (evt_code),
    .full  (full),
    .empty (empty),
    .count (evt_count)
  );

  // Set beats clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     overflow <= 1'b0;
    else if (push & full & ~pop) overflow <= 1'b1;
    else if (clr_ovf)            overflow <= 1'b0;
  end

endmodule
